immediate_packer: RTL and testbench
===================================

IMMEDIATE_PACKER -- requirements
Module: immediate_packer

Interface
REQ-001 The block SHALL have a single clock `clk` and a reset `rst`; reset SHALL be asynchronous and active-high.
REQ-002 Ports (name, direction, width, meaning):
- `clk`, in, 1, rising-edge clock.
- `rst`, in, 1, async active-high reset.
- `in_valid`, in, 1, request present.
- `in_ready`, out, 1, request accepted this cycle.
- `imm`, in, 32, immediate value to encode.
- `ImmSrc`, in, 3, immediate type: 000 I, 001 S, 010 B, 011 U, 100 J; 101–111 illegal.
- `base_field`, in, 25, instruction bits [31:7] holding the non-immediate fields (rd/rs1/rs2/funct3).
- `out_valid`, out, 1, result present.
- `out_ready`, in, 1, consumer accepts the result.
- `field_out`, out, 25, packed instruction bits [31:7].
- `err`, out, 1, immediate not representable or ImmSrc illegal.
- `err_cnt`, out, 8, saturating error count.

Function
REQ-003 Transfers: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
REQ-004 The pipeline SHALL have two register stages: S1 captures the inputs, S2 holds the packed result; with no stall, latency is 2 cycles and throughput is 1 per cycle.
REQ-005 Stage advance rules:
- S2 loads from S1 when S1 is valid and (S2 is empty or out_ready=1).
- S1 loads on an input transfer.
- in_ready = !(S1 valid && S2 valid && !out_ready).
- No transaction SHALL be lost or duplicated.
REQ-006 field_out SHALL equal base_field with the immediate positions overwritten (index k = instruction bit k+7):
- I: [24:13]=imm[11:0].
- S: [24:18]=imm[11:5]; [4:0]=imm[4:0].
- B: [24]=imm[12]; [0]=imm[11]; [23:18]=imm[10:5]; [4:1]=imm[4:1].
- U: [24:5]=imm[31:12].
- J: [24]=imm[20]; [12:5]=imm[19:12]; [13]=imm[11]; [23:14]=imm[10:1].
REQ-007 For illegal ImmSrc, field_out SHALL equal base_field unchanged.
REQ-008 field_out, err, and out_valid SHALL be registered outputs of S2 and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-009 Simultaneous output transfer and S1→S2 advance in the same cycle SHALL replace S2 contents with no bubble.

Reset
REQ-010 While rst=1, the following SHALL be forced to zero: S1/S2 valid, out_valid, field_out, err, err_cnt.
REQ-011 in_ready SHALL be 1 one cycle after rst deasserts.
REQ-012 Reset asserted mid-operation SHALL discard all in-flight requests; no out_valid SHALL appear for them after reset.

Configuration
REQ-013 Macro `IMM_RANGE_CHECK_EN`, when defined, SHALL compute err in S1 as follows:
- I/S: imm[31:11] not all equal.
- B: imm[31:12] not all equal, or imm[0]=1.
- U: imm[11:0] != 0.
- J: imm[31:20] not all equal, or imm[0]=1.
- Illegal ImmSrc: err=1.
REQ-014 With `IMM_RANGE_CHECK_EN` defined, err_cnt SHALL increment by 1 on each output transfer with err=1 and saturate at 255.
REQ-015 With `IMM_RANGE_CHECK_EN` undefined, err and err_cnt SHALL be constant 0 and packing SHALL be unchanged (out-of-range bits silently truncated).

Verification
REQ-016 I-type: imm=0xFFFFF800, ImmSrc=000, base_field=0 -> field_out=0x1000000, err=0, exactly 2 cycles after acceptance.
REQ-017 U-type: imm=0x12345000, ImmSrc=011, base_field=0x000001F -> field_out=0x02468BF, err=0.
REQ-018 B-type: imm=0xFFFFFFFE, base_field=0 -> field_out=0x1FC001F, err=0; then imm=0x00000003 -> err=1, err_cnt=1 (macro on) / err=0, err_cnt=0 (macro off).
REQ-019 Backpressure: out_ready=0 with 3 back-to-back requests ->
- in_ready drops after 2 are accepted.
- Releasing out_ready delivers all 3 in order, unchanged, with no duplicates.
REQ-020 Reset: assert rst while 2 requests are in flight -> out_valid=0, err_cnt=0; the next request completes normally after reset.
REQ-021 J-type: imm=0x00100000 -> err=1 (macro on); ImmSrc=111 -> field_out=base_field, err=1 (macro on).

Source files
------------

// File: rtl/immediate_packer_if.sv
// Request/result bundle for immediate_packer: request handshake, packed-field result and
// error reporting. The packer sits on the slave side.
interface immediate_packer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm;
    logic [2:0]  ImmSrc;
    logic [24:0] base_field;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] field_out;
    logic        err;
    logic [7:0]  err_cnt;

    modport master (
        output in_valid,
        output imm,
        output ImmSrc,
        output base_field,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  field_out,
        input  err,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        input  imm,
        input  ImmSrc,
        input  base_field,
        input  out_ready,
        output in_ready,
        output out_valid,
        output field_out,
        output err,
        output err_cnt
    );
endinterface

// File: rtl/immediate_packer.sv
// Two-stage pipeline that scatters an immediate into RISC-V instruction bits [31:7].
// Define IMM_RANGE_CHECK_EN to enable range checking (err) and the saturating error counter.
module immediate_packer (
    input  logic              clk,
    input  logic              rst,
    immediate_packer_if.slave bus
);

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmU = 3'b011;
    localparam logic [2:0] ImmJ = 3'b100;

    logic        s1_valid_q, s1_valid_d;
    logic [31:0] s1_imm_q, s1_imm_d;
    logic [2:0]  s1_src_q, s1_src_d;
    logic [24:0] s1_base_q, s1_base_d;

    logic        s2_valid_q, s2_valid_d;
    logic [24:0] s2_field_q, s2_field_d;

    logic        in_xfer;
    logic        out_xfer;
    logic        s2_load;
    logic [24:0] packed_field;

    assign bus.in_ready = !(s1_valid_q && s2_valid_q && !bus.out_ready);
    assign in_xfer      = bus.in_valid && bus.in_ready;
    assign out_xfer     = s2_valid_q && bus.out_ready;
    assign s2_load      = s1_valid_q && (!s2_valid_q || bus.out_ready);

    // Field index k corresponds to instruction bit k+7.
    always_comb begin
        packed_field = s1_base_q;
        case (s1_src_q)
            ImmI: packed_field[24:13] = s1_imm_q[11:0];
            ImmS: begin
                packed_field[24:18] = s1_imm_q[11:5];
                packed_field[4:0]   = s1_imm_q[4:0];
            end
            ImmB: begin
                packed_field[24]    = s1_imm_q[12];
                packed_field[0]     = s1_imm_q[11];
                packed_field[23:18] = s1_imm_q[10:5];
                packed_field[4:1]   = s1_imm_q[4:1];
            end
            ImmU: packed_field[24:5] = s1_imm_q[31:12];
            ImmJ: begin
                packed_field[24]    = s1_imm_q[20];
                packed_field[12:5]  = s1_imm_q[19:12];
                packed_field[13]    = s1_imm_q[11];
                packed_field[23:14] = s1_imm_q[10:1];
            end
            default: packed_field = s1_base_q;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_imm_d   = s1_imm_q;
        s1_src_d   = s1_src_q;
        s1_base_d  = s1_base_q;
        if (in_xfer) begin
            s1_valid_d = 1'b1;
            s1_imm_d   = bus.imm;
            s1_src_d   = bus.ImmSrc;
            s1_base_d  = bus.base_field;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // A load while draining replaces S2 in place, so no bubble is inserted.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_field_d = s2_field_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_field_d = packed_field;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_imm_q   <= '0;
            s1_src_q   <= '0;
            s1_base_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_field_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_imm_q   <= s1_imm_d;
            s1_src_q   <= s1_src_d;
            s1_base_q  <= s1_base_d;
            s2_valid_q <= s2_valid_d;
            s2_field_q <= s2_field_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.field_out = s2_field_q;

`ifdef IMM_RANGE_CHECK_EN
    logic       s1_err;
    logic       s2_err_q, s2_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // A field is representable when all bits above the sign position match it.
    always_comb begin
        s1_err = 1'b0;
        case (s1_src_q)
            ImmI, ImmS: s1_err = !((&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]));
            ImmB:       s1_err = !((&s1_imm_q[31:12]) || !(|s1_imm_q[31:12])) || s1_imm_q[0];
            ImmU:       s1_err = |s1_imm_q[11:0];
            ImmJ:       s1_err = !((&s1_imm_q[31:20]) || !(|s1_imm_q[31:20])) || s1_imm_q[0];
            default:    s1_err = 1'b1;
        endcase
    end

    always_comb begin
        s2_err_d  = s2_err_q;
        err_cnt_d = err_cnt_q;
        if (s2_load) begin
            s2_err_d = s1_err;
        end
        if (out_xfer && s2_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            s2_err_q  <= s2_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err     = s2_err_q;
    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err     = 1'b0;
    assign bus.err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_immediate_packer.sv
// Directed bench for immediate_packer; expectations adapt to whether IMM_RANGE_CHECK_EN is set.
module tb_immediate_packer;

`ifdef IMM_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    immediate_packer_if bus ();

    immediate_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] imm, input logic [2:0] src, input logic [24:0] base);
        bus.in_valid   = 1'b1;
        bus.imm        = imm;
        bus.ImmSrc     = src;
        bus.base_field = base;
    endtask

    // Single request with out_ready high: result must appear exactly two edges after acceptance.
    task automatic xfer1(input string tag, input logic [31:0] imm, input logic [2:0] src,
                         input logic [24:0] base, input logic [24:0] exp_field,
                         input logic exp_err);
        drive(imm, src, base);
        #1;
        chk({tag, "_rdy"}, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_lat1"}, bus.out_valid, 0);
        step();
        chk({tag, "_vld"}, bus.out_valid, 1);
        chk({tag, "_field"}, bus.field_out, exp_field);
        chk({tag, "_err"}, bus.err, exp_err);
        step();
        chk({tag, "_nodup"}, bus.out_valid, 0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.imm        = '0;
        bus.ImmSrc     = '0;
        bus.base_field = '0;
        bus.out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_field", bus.field_out, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", bus.in_ready, 1);

        xfer1("i_neg", 32'hFFFFF800, 3'b000, 25'h0, 25'h1000000, 1'b0);
        xfer1("u_basic", 32'h12345000, 3'b011, 25'h000001F, 25'h02468BF, 1'b0);
        xfer1("b_neg2", 32'hFFFFFFFE, 3'b010, 25'h0, 25'h1FC001F, 1'b0);
        xfer1("b_odd", 32'h00000003, 3'b010, 25'h0, 25'h0000002, RC);
        chk("b_odd_cnt", bus.err_cnt, RC ? 32'd1 : 32'd0);
        xfer1("s_mix", 32'h000005A5, 3'b001, 25'h0015500, 25'h0B55505, 1'b0);
        xfer1("j_ovf", 32'h00100000, 3'b100, 25'h0, 25'h1000000, RC);
        xfer1("j_neg", 32'hFFFFF002, 3'b100, 25'h0, 25'h1005FE0, 1'b0);
        xfer1("illegal", 32'hDEADBEEF, 3'b111, 25'h1ABCDEF, 25'h1ABCDEF, RC);
        chk("cnt_after3", bus.err_cnt, RC ? 32'd3 : 32'd0);

        // Backpressure: three back-to-back I-type requests while the consumer stalls.
        bus.out_ready = 1'b0;
        drive(32'h00000001, 3'b000, 25'h0);
        #1;
        chk("bp_rdy_a", bus.in_ready, 1);
        step();
        drive(32'h00000002, 3'b000, 25'h0);
        #1;
        chk("bp_rdy_b", bus.in_ready, 1);
        step();
        drive(32'h000007FF, 3'b000, 25'h0);
        #1;
        chk("bp_rdy_c_blocked", bus.in_ready, 0);
        chk("bp_a_vld", bus.out_valid, 1);
        chk("bp_a_field", bus.field_out, 25'h0002000);
        step();
        step();
        chk("bp_a_hold", bus.field_out, 25'h0002000);
        chk("bp_still_blocked", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_rdy_release", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_b_vld", bus.out_valid, 1);
        chk("bp_b_field", bus.field_out, 25'h0004000);
        step();
        chk("bp_c_vld", bus.out_valid, 1);
        chk("bp_c_field", bus.field_out, 25'h0FFE000);
        step();
        chk("bp_drained", bus.out_valid, 0);

        // Stream illegal requests to push the error counter into saturation.
        drive(32'h0, 3'b101, 25'h0);
        for (int i = 0; i < 260; i++) step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        chk("cnt_saturated", bus.err_cnt, RC ? 32'd255 : 32'd0);

        // Reset with two requests in flight.
        bus.out_ready = 1'b0;
        drive(32'h00000005, 3'b000, 25'h0);
        step();
        drive(32'h00000003, 3'b010, 25'h0);
        step();
        bus.in_valid = 1'b0;
        chk("inflight_vld", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_err_cnt", bus.err_cnt, 0);
        chk("midrst_field", bus.field_out, 0);
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("post_rst_quiet", bus.out_valid, 0);
        xfer1("after_rst", 32'hABCDE000, 3'b011, 25'h0, 25'h1579BC0, 1'b0);
        chk("after_rst_cnt", bus.err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
